vga_pixel_pipe: RTL and testbench
=================================

# vga_pixel_pipe

Parametrised VGA scan-out pipeline: generates raster timing, drives a synchronous framebuffer read port, and maps each indexed pixel through a runtime-writable palette to RGB. It replaces the fixed 640x480/4-bit/hard-coded-palette display path between the framebuffer BRAM and the VGA pins, adding programmable timing, configurable memory latency, a writable palette and a 2x pixel/line-doubling mode. Everything runs in the pixel-clock domain.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width (lines)
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted sync level (0 = active-low)
- PIX_BITS, 4, framebuffer index width; palette holds 2^PIX_BITS entries
- COLOR_BITS, 4, width of each of R, G, B
- MEM_LAT, 1, framebuffer read latency in cycles (fbAddr registered -> fbData valid), >= 1
- ADDR_W, 19, framebuffer address width

Ports:
- pixelClk  in  1  pixel clock; single clock domain
- resetN  in  1  asynchronous, active-low reset
- enable  in  1  raster run; low holds counters at (0,0)
- scale2x  in  1  pixel/line doubling; sampled at frame start
- fbAddr  out  ADDR_W  framebuffer read address
- fbEn  out  1  framebuffer read enable
- fbData  in  PIX_BITS  framebuffer read data, MEM_LAT cycles after fbAddr
- palWe  in  1  palette write strobe
- palAddr  in  PIX_BITS  palette write index
- palData  in  3*COLOR_BITS  palette entry {R,G,B}
- hSync / vSync  out  1  sync outputs, aligned with RGB
- VGA_R / VGA_G / VGA_B  out  COLOR_BITS  pixel colour; 0 outside the active area
- frameStart  out  1  one-cycle pulse coincident with output pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. hCnt wraps H_TOTAL-1 -> 0 and increments vCnt; vCnt wraps V_TOTAL-1 -> 0.
- active = hCnt < H_ACTIVE && vCnt < V_ACTIVE.
- hSync asserted for H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC; vSync likewise on vCnt. Asserted = *_POL, else inverted.
- Address: no multiplier. lineBase and fbAddr counters. Normal mode: fbAddr = lineBase + hCnt; lineBase += H_ACTIVE after each active line. scale2x mode: fbAddr = lineBase + (hCnt>>1); lineBase += H_ACTIVE/2 only after odd lines. lineBase clears at frame start. Widths truncate to ADDR_W.
- scale2x captured when counters are at (0,0); changes mid-frame are ignored until next frame.
- Palette: 2^PIX_BITS x 3*COLOR_BITS register file. palWe writes palData to palAddr at the clock edge. Reset value of entry i = i (truncated/zero-extended to COLOR_BITS) in every channel (grey ramp). A lookup of the entry being written in the same cycle returns the old value. Mid-frame writes are legal and affect subsequent lookups.
- enable low: hCnt, vCnt, lineBase held at 0, fbEn = 0; the delay pipeline keeps shifting blank, sync-inactive entries. enable rising: frame starts at (0,0) on the next edge.

## Timing
- L = MEM_LAT + 2 cycles from counter state to pins.
- Cycle t: counters at (h,v). t+1: fbAddr/fbEn registered. t+1+MEM_LAT: fbData valid; palette read. t+2+MEM_LAT: VGA_R/G/B, hSync, vSync, frameStart registered.
- active, hSync, vSync, frame-start delayed through an L-stage shift register so all outputs align with RGB.
- Reset values: fbAddr=0, fbEn=0, RGB=0, frameStart=0, hSync=~HSYNC_POL, vSync=~VSYNC_POL, all pipeline stages blank/inactive, palette = grey ramp.
- Reset mid-frame: all state returns to reset values asynchronously; raster restarts at (0,0) on the first edge with resetN high and enable high.
- enable deasserted mid-frame: counters go to 0 next edge; outputs blank and syncs go inactive within L cycles; no partial frame is resumed.

## Test plan
- Reset: hold resetN low, check every output at its reset value; release with enable=1 -> frameStart first pulses 3 cycles (MEM_LAT=1) after release edge, then every 800*525 = 420000 cycles.
- Default timing: measure hSync low for 96 cycles starting 656 cycles after a line's first pixel; vSync low for 2 lines starting at line 490; RGB zero for 160 of every 800 cycles.
- Address sequence: fbAddr runs 0..639 on line 0, 640..1279 on line 1, last active = 307199; fbEn high exactly 640 cycles per active line.
- Palette: write entry 5 = 0xABC; framebuffer model returns index 5 -> output RGB = A,B,C; unwritten index 3 -> 3,3,3; same-cycle write/read of index 5 returns old value.
- scale2x=1: lines 0 and 1 both address 0,0,1,1,...,319,319; line 2 starts at 320; toggling scale2x mid-frame has no effect until next frame.
- MEM_LAT=3 with a latency-3 memory model: RGB and syncs stay aligned (L=5); deassert enable mid-line -> outputs blank within 5 cycles, reassert -> new frame from address 0.

Source files
------------

// File: rtl/vga_pixel_pipe.sv
// VGA scan-out pipeline: raster timing generator, framebuffer read-address
// generation (with optional 2x pixel/line doubling), writable palette and an
// aligned output stage. Counter state reaches the pins MEM_LAT+2 cycles later;
// the sync/active/frame-start tags ride a shift register so they line up with
// the palette output.
module vga_pixel_pipe #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int PIX_BITS   = 4,
    parameter int COLOR_BITS = 4,
    parameter int MEM_LAT    = 1,
    parameter int ADDR_W     = 19
) (
    input  logic                    pixelClk,
    input  logic                    resetN,
    input  logic                    enable,
    input  logic                    scale2x,
    output logic [ADDR_W-1:0]       fbAddr,
    output logic                    fbEn,
    input  logic [PIX_BITS-1:0]     fbData,
    input  logic                    palWe,
    input  logic [PIX_BITS-1:0]     palAddr,
    input  logic [3*COLOR_BITS-1:0] palData,
    output logic                    hSync,
    output logic                    vSync,
    output logic [COLOR_BITS-1:0]   VGA_R,
    output logic [COLOR_BITS-1:0]   VGA_G,
    output logic [COLOR_BITS-1:0]   VGA_B,
    output logic                    frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare bit so sync-end compares never overflow when a back porch is 0.
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);
    localparam int PAL_N   = 2 ** PIX_BITS;
    localparam int CW      = 3 * COLOR_BITS;
    // Tag stages before the output register: edge 1 .. edge MEM_LAT+1.
    localparam int DEPTH   = MEM_LAT + 1;

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_C  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_C  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] HALF_STEP = ADDR_W'(H_ACTIVE / 2);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
    } tag_t;

    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic [ADDR_W-1:0] line_base;
    logic              scale_q;
    logic              scale_eff;
    logic              at_origin;
    logic              h_act;
    logic              v_act;
    logic [H_W-1:0]    col;
    tag_t              cur_tag;
    tag_t              tag_pipe [DEPTH];
    tag_t              last_tag;
    logic [CW-1:0]     palette [PAL_N];
    logic [CW-1:0]     pal_entry;

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    // The frame's own first pixel already uses the freshly sampled mode.
    assign scale_eff = at_origin ? scale2x : scale_q;
    assign h_act     = h_cnt < H_ACT_C;
    assign v_act     = v_cnt < V_ACT_C;
    assign col       = scale_eff ? (h_cnt >> 1) : h_cnt;

    assign cur_tag.act = h_act && v_act;
    assign cur_tag.hs  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign cur_tag.vs  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign cur_tag.fs  = at_origin;

    assign last_tag  = tag_pipe[DEPTH-1];
    assign pal_entry = palette[fbData];

    // Raster counters, per-line framebuffer base and per-frame scale capture.
    always_ff @(posedge pixelClk or negedge resetN) begin
        if (!resetN) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            line_base <= '0;
            scale_q   <= 1'b0;
        end else begin
            scale_q <= scale_eff;
            if (!enable) begin
                h_cnt     <= '0;
                v_cnt     <= '0;
                line_base <= '0;
            end else if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt     <= '0;
                    line_base <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    // In doubled mode each source line is shown twice, so the
                    // base only moves after the second (odd) copy.
                    if (v_act && !scale_eff)
                        line_base <= line_base + LINE_STEP;
                    else if (v_act && v_cnt[0])
                        line_base <= line_base + HALF_STEP;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Framebuffer request stage plus the tag delay line that tracks it.
    always_ff @(posedge pixelClk or negedge resetN) begin
        if (!resetN) begin
            fbAddr <= '0;
            fbEn   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                tag_pipe[i] <= '0;
        end else begin
            fbAddr      <= line_base + ADDR_W'(col);
            fbEn        <= enable && cur_tag.act;
            tag_pipe[0] <= enable ? cur_tag : '0;
            for (int i = 1; i < DEPTH; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Palette register file; reads are combinational so a same-edge write
    // is seen only by later lookups.
    always_ff @(posedge pixelClk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < PAL_N; i++)
                palette[i] <= {3{COLOR_BITS'(i)}};
        end else if (palWe) begin
            palette[palAddr] <= palData;
        end
    end

    // Output register: colour blanked outside the active area, syncs mapped
    // to their configured polarity.
    always_ff @(posedge pixelClk or negedge resetN) begin
        if (!resetN) begin
            VGA_R      <= '0;
            VGA_G      <= '0;
            VGA_B      <= '0;
            hSync      <= ~HSYNC_POL;
            vSync      <= ~VSYNC_POL;
            frameStart <= 1'b0;
        end else begin
            VGA_R      <= last_tag.act ? pal_entry[CW-1 -: COLOR_BITS] : '0;
            VGA_G      <= last_tag.act ? pal_entry[2*COLOR_BITS-1 -: COLOR_BITS] : '0;
            VGA_B      <= last_tag.act ? pal_entry[COLOR_BITS-1 -: COLOR_BITS] : '0;
            hSync      <= last_tag.hs ? HSYNC_POL : ~HSYNC_POL;
            vSync      <= last_tag.vs ? VSYNC_POL : ~VSYNC_POL;
            frameStart <= last_tag.fs;
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe using a reduced raster (16x8 total, 8x4 active)
// so whole frames fit in a short run. Two instances: MEM_LAT=1 ("a") and
// MEM_LAT=3 ("b"), each fed by its own framebuffer model whose pixel index
// is the low nibble of the address.
module tb_vga_pixel_pipe;

    localparam int AW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b, scale_a, scale_b;
    logic       pal_we_a, pal_we_b;
    logic [3:0] pal_addr_a, pal_addr_b;
    logic [11:0] pal_data_a, pal_data_b;

    logic [AW-1:0] fb_addr_a, fb_addr_b;
    logic          fb_en_a, fb_en_b;
    logic [3:0]    fb_data_a, fb_data_b, d1_b, d2_b;
    logic          hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
    logic [3:0]    r_a, g_a, b_a, r_b, g_b, b_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    vga_pixel_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .PIX_BITS(4), .COLOR_BITS(4), .MEM_LAT(1), .ADDR_W(AW)
    ) u_a (
        .pixelClk(clk), .resetN(rst_n), .enable(en_a), .scale2x(scale_a),
        .fbAddr(fb_addr_a), .fbEn(fb_en_a), .fbData(fb_data_a),
        .palWe(pal_we_a), .palAddr(pal_addr_a), .palData(pal_data_a),
        .hSync(hs_a), .vSync(vs_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
        .frameStart(fs_a)
    );

    vga_pixel_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .PIX_BITS(4), .COLOR_BITS(4), .MEM_LAT(3), .ADDR_W(AW)
    ) u_b (
        .pixelClk(clk), .resetN(rst_n), .enable(en_b), .scale2x(scale_b),
        .fbAddr(fb_addr_b), .fbEn(fb_en_b), .fbData(fb_data_b),
        .palWe(pal_we_b), .palAddr(pal_addr_b), .palData(pal_data_b),
        .hSync(hs_b), .vSync(vs_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
        .frameStart(fs_b)
    );

    // Framebuffer models: latency 1 and latency 3.
    always @(posedge clk) begin
        fb_data_a <= fb_addr_a[3:0];
        d1_b      <= fb_addr_b[3:0];
        d2_b      <= d1_b;
        fb_data_b <= d2_b;
    end

    typedef struct {
        int         k;
        bit         on_b;
        logic       en;
        logic [7:0] addr;
        logic [3:0] r, g, b;
        logic       hs, vs, fs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int k, bit on_b, logic en, logic [7:0] addr,
                                logic [3:0] r, logic [3:0] g, logic [3:0] b,
                                logic hs, logic vs, logic fs);
        vec_t x;
        x.k = k; x.on_b = on_b; x.en = en; x.addr = addr;
        x.r = r; x.g = g; x.b = b; x.hs = hs; x.vs = vs; x.fs = fs;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_rgb(input string name, input bit on_b,
                           input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        chk({name, "_rgb"}, on_b ? {r_b, g_b, b_b} : {r_a, g_a, b_a}, {r, g, b});
    endtask

    task automatic apply(input vec_t x);
        string n;
        n = $sformatf("vec%0d%s", x.k, x.on_b ? "b" : "a");
        chk({n, "_fben"}, x.on_b ? fb_en_b : fb_en_a, x.en);
        if (x.en)
            chk({n, "_addr"}, x.on_b ? fb_addr_b : fb_addr_a, x.addr);
        chk_rgb(n, x.on_b, x.r, x.g, x.b);
        chk({n, "_hs"}, x.on_b ? hs_b : hs_a, x.hs);
        chk({n, "_vs"}, x.on_b ? vs_b : vs_a, x.vs);
        chk({n, "_fs"}, x.on_b ? fs_b : fs_a, x.fs);
    endtask

    task automatic chk_reset(input bit on_b);
        string n;
        n = on_b ? "rst_b" : "rst_a";
        chk({n, "_addr"}, on_b ? fb_addr_b : fb_addr_a, 0);
        chk({n, "_fben"}, on_b ? fb_en_b : fb_en_a, 0);
        chk_rgb(n, on_b, 0, 0, 0);
        chk({n, "_hs"}, on_b ? hs_b : hs_a, 1);
        chk({n, "_vs"}, on_b ? vs_b : vs_a, 1);
        chk({n, "_fs"}, on_b ? fs_b : fs_a, 0);
    endtask

    initial begin
        // Edge k: fbAddr/fbEn reflect counter state k-1; pins reflect state
        // k-3 (a) or k-5 (b). State n = 16*v + h within a 128-cycle frame.
        vecs.push_back(mk(1,   0, 1, 0,  0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(2,   0, 1, 1,  0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(3,   0, 1, 2,  0, 0, 0,  1, 1, 1));
        vecs.push_back(mk(4,   0, 1, 3,  1, 1, 1,  1, 1, 0));
        vecs.push_back(mk(4,   1, 1, 3,  0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(5,   1, 1, 4,  0, 0, 0,  1, 1, 1));
        vecs.push_back(mk(6,   1, 1, 5,  1, 1, 1,  1, 1, 0));
        vecs.push_back(mk(10,  0, 0, 0,  7, 7, 7,  1, 1, 0));
        vecs.push_back(mk(11,  0, 0, 0,  0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(12,  1, 0, 0,  7, 7, 7,  1, 1, 0));
        vecs.push_back(mk(13,  0, 0, 0,  0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(13,  1, 0, 0,  0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(15,  0, 0, 0,  0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(15,  1, 0, 0,  0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(16,  0, 0, 0,  0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(17,  0, 1, 8,  0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(19,  0, 1, 10, 8, 8, 8,  1, 1, 0));
        vecs.push_back(mk(23,  1, 1, 14, 10, 10, 10, 1, 1, 0));
        vecs.push_back(mk(58,  0, 0, 0,  15, 15, 15, 1, 1, 0));
        vecs.push_back(mk(67,  0, 0, 0,  0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(83,  0, 0, 0,  0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(94,  0, 0, 0,  0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(115, 0, 0, 0,  0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(131, 0, 1, 2,  0, 0, 0,  1, 1, 1));
        vecs.push_back(mk(132, 0, 1, 3,  1, 1, 1,  1, 1, 0));

        rst_n = 1'b0;
        en_a = 1'b1; en_b = 1'b1; scale_a = 1'b0; scale_b = 1'b0;
        pal_we_a = 1'b0; pal_we_b = 1'b0;
        pal_addr_a = '0; pal_addr_b = '0; pal_data_a = '0; pal_data_b = '0;

        for (int i = 0; i < 3; i++) step();
        chk_reset(0);
        chk_reset(1);

        rst_n = 1'b1;
        cyc   = 0;

        foreach (vecs[i]) begin
            step_to(vecs[i].k);
            apply(vecs[i]);
        end

        // Palette write of entry 5 landing on the same edge that looks it up.
        step_to(135);
        pal_we_a = 1'b1; pal_addr_a = 4'd5; pal_data_a = 12'hABC;
        step();
        chk_rgb("pal_same_cycle", 0, 5, 5, 5);
        pal_we_a = 1'b0;
        step_to(262);
        chk_rgb("pal_unwritten3", 0, 3, 3, 3);
        step_to(264);
        chk_rgb("pal_written5", 0, 4'hA, 4'hB, 4'hC);
        step_to(296);
        chk_rgb("pal_written5_line2", 0, 4'hA, 4'hB, 4'hC);

        // Doubling: armed mid frame 3, takes effect at frame 4 (edge 385).
        step_to(300);
        scale_a = 1'b1;
        step_to(385); chk("x2_l0_h0", fb_addr_a, 0);
        step_to(388); chk("x2_l0_h3", fb_addr_a, 1);
        step_to(392); chk("x2_l0_h7", fb_addr_a, 3);
        step_to(407); chk("x2_l1_h6", fb_addr_a, 3);
        step_to(409); chk_rgb("x2_l1_h6", 0, 3, 3, 3);
        step_to(417); chk("x2_l2_h0", fb_addr_a, 4);
        step_to(420);
        scale_a = 1'b0;
        step_to(438); chk("x2_hold_l3_h5", fb_addr_a, 6);
        step_to(532); chk("x1_next_frame", fb_addr_a, 11);

        // MEM_LAT=3 instance: drop enable mid active line, then restart.
        step_to(644);
        en_b = 1'b0;
        step(); chk("dis_fben", fb_en_b, 0);
        step_to(648); chk_rgb("dis_drain", 1, 3, 3, 3);
        step_to(649);
        chk_rgb("dis_blank", 1, 0, 0, 0);
        chk("dis_hs", hs_b, 1);
        chk("dis_vs", vs_b, 1);
        step_to(650); chk_rgb("dis_blank_l", 1, 0, 0, 0);
        chk("dis_fs", fs_b, 0);
        step_to(660);
        en_b = 1'b1;
        step();
        chk("re_addr0", fb_addr_b, 0);
        chk("re_fben", fb_en_b, 1);
        step(); chk("re_addr1", fb_addr_b, 1);
        step_to(664); chk("re_fs_early", fs_b, 0);
        step_to(665); chk("re_fs", fs_b, 1);
        chk_rgb("re_px0", 1, 0, 0, 0);
        step_to(666); chk_rgb("re_px1", 1, 1, 1, 1);
        chk("re_fs_pulse", fs_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
